arashi_thread_arbiter: RTL

Round-robin read arbiter that sits directly downstream of the per-thread caches. It samples each cache's `avail`, issues at most one registered `r_ena` per cycle, and captures the returned word two cycles later. It forwards the words through a small credit-protected output FIFO to a single valid/ready consumer. This merges N thread streams into one ordered stream without ever over-reading a cache or dropping a word under backpressure.

---
 rtl/arashi_pkg.sv | 18 +
 rtl/arashi_arb_out_fifo.sv | 73 +++++++
 rtl/arashi_thread_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/arashi_pkg.sv
// Shared definitions for the arashi thread arbiter.
//   ARASHI_MAX_THREADS : largest thread count any arashi block supports
//   tid_t              : thread index wide enough for ARASHI_MAX_THREADS
//   ARB_PIPE_LAT       : words in flight between a grant and its FIFO push
//   rr_candidate       : round-robin search position helper
package arashi_pkg;

    localparam int ARASHI_MAX_THREADS = 16;
    localparam int ARB_PIPE_LAT       = 2;

    typedef logic [$clog2(ARASHI_MAX_THREADS)-1:0] tid_t;

    // Thread index visited at step 'offset' of a search that starts after 'last'.
    function automatic tid_t rr_candidate(input int last, input int offset, input int n);
        return tid_t'((last + offset) % n);
    endfunction

endpackage

// File: rtl/arashi_arb_out_fifo.sv
// Show-ahead FIFO used as the arbiter's output buffer.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   push, push_data  : write one entry at the end of the cycle
//   pop              : drop the head entry (ignored when empty)
//   head_data        : current head entry, zero while empty
//   empty            : no entries stored
//   count            : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module arashi_arb_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;

    // Storage carries no reset; the head is gated to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;

    // The upstream credit scheme must never let a write arrive while full.
    no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

// File: rtl/arashi_thread_arbiter.sv
// Round-robin read arbiter merging N per-thread cache streams into one
// valid/ready stream.
//   S0: pick a requesting thread (avail masked by FIFO credit)
//   S1: drive the registered one-hot r_ena to that cache
//   S2: capture rd_data of that thread into the output FIFO
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   avail   [N]          : cache may be read next cycle
//   rd_data [N][DW]      : per-cache read data, valid the cycle after r_ena
//   r_ena   [N]          : registered one-hot read enable
//   out_valid/out_ready  : output handshake
//   out_data [DW]        : output word
//   out_tid  [TID_W]     : source thread (only with ARASHI_ARB_TID_EN)
// Build option: define ARASHI_ARB_TID_EN to carry the thread id with each word.
module arashi_thread_arbiter
    import arashi_pkg::*;
#(
    parameter int N_THREADS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TID_W      = $clog2(N_THREADS)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [N_THREADS-1:0]                 avail,
    input  logic [N_THREADS-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [N_THREADS-1:0]                 r_ena,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data
`ifdef ARASHI_ARB_TID_EN
    ,
    output logic [TID_W-1:0]                     out_tid
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(ARB_PIPE_LAT + 1);
`ifdef ARASHI_ARB_TID_EN
    localparam int ENTRY_W = DATA_WIDTH + TID_W;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic                 push;
    logic                 pop;
    logic [INF_W-1:0]     inflight;
    logic                 credit_ok;
    logic [N_THREADS-1:0] req;
    logic                 grant_found;
    logic [TID_W-1:0]     grant_idx;
    logic [N_THREADS-1:0] r_ena_next;
    logic [N_THREADS-1:0] r_ena_reg;
    logic [TID_W-1:0]     last_grant_reg;
    logic                 s1_valid_reg;
    logic [TID_W-1:0]     s1_tid_reg;
    logic                 s2_valid_reg;
    logic [TID_W-1:0]     s2_tid_reg;

    // Every granted word must already own a FIFO slot. Words still in S1/S2
    // count against the FIFO, and a pop in the same cycle is deliberately not
    // credited, so the FIFO can never overflow.
    assign inflight  = INF_W'(s1_valid_reg) + INF_W'(s2_valid_reg);
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_req
        assign req[gi] = avail[gi] & credit_ok;
    end

    // Search starts just after the previous winner, so a thread that was
    // just served has lowest priority on the next cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            if (!grant_found && req[TID_W'(rr_candidate(int'(last_grant_reg), k, N_THREADS))]) begin
                grant_found = 1'b1;
                grant_idx   = TID_W'(rr_candidate(int'(last_grant_reg), k, N_THREADS));
            end
        end
    end

    always_comb begin
        r_ena_next = '0;
        if (grant_found) begin
            r_ena_next[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_reg <= TID_W'(N_THREADS - 1);
            r_ena_reg      <= '0;
            s1_valid_reg   <= 1'b0;
            s1_tid_reg     <= '0;
            s2_valid_reg   <= 1'b0;
            s2_tid_reg     <= '0;
        end else begin
            r_ena_reg    <= r_ena_next;
            s1_valid_reg <= grant_found;
            s1_tid_reg   <= grant_idx;
            s2_valid_reg <= s1_valid_reg;
            s2_tid_reg   <= s1_tid_reg;
            if (grant_found) begin
                last_grant_reg <= grant_idx;
            end
        end
    end

    assign r_ena = r_ena_reg;

    // Only the granted lane is taken; other lanes are not OR-ed in.
    assign push = s2_valid_reg;
`ifdef ARASHI_ARB_TID_EN
    assign push_entry = {s2_tid_reg, rd_data[s2_tid_reg]};
`else
    assign push_entry = rd_data[s2_tid_reg];
`endif

    arashi_arb_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head_entry[DATA_WIDTH-1:0];
`ifdef ARASHI_ARB_TID_EN
    assign out_tid   = head_entry[ENTRY_W-1 -: TID_W];
`endif

endmodule
